cl_ocl_arb: RTL and testbench

Two-master AXI-Lite arbiter that shares the single OCL register slave (hello-world / VLED register block behind the OCL register slice) between the PCIe OCL path (master 0) and a second register master (master 1, e.g. an internal debug/sequencer master). One transaction is in flight at a time. Grants are round-robin between masters and alternate write/read within a master. Every channel is forwarded combinationally from registered grant state, so the block adds one arbitration cycle per transaction and no data buffering.

---
 rtl/cl_ocl_arb.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cl_ocl_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_ocl_arb.sv
// cl_ocl_arb: two-master AXI-Lite arbiter in front of the single OCL register
// slave. One transaction is in flight at a time. Grants rotate round-robin
// between the masters, and each master alternates write/read when it offers
// both at once. All channels are forwarded combinationally from the
// registered grant, so no data is buffered here.
module cl_ocl_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_main_a0,
  input  logic                  rst_main_sync,
  // master 0
  input  logic                  m0_awvalid,
  input  logic [ADDR_W-1:0]     m0_awaddr,
  output logic                  m0_awready,
  input  logic                  m0_wvalid,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic                  m0_wready,
  output logic                  m0_bvalid,
  output logic [1:0]            m0_bresp,
  input  logic                  m0_bready,
  input  logic                  m0_arvalid,
  input  logic [ADDR_W-1:0]     m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  input  logic                  m0_rready,
  // master 1
  input  logic                  m1_awvalid,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [1:0]            m1_bresp,
  input  logic                  m1_bready,
  input  logic                  m1_arvalid,
  input  logic [ADDR_W-1:0]     m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  input  logic                  m1_rready,
  // shared slave
  output logic                  s_awvalid,
  output logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [1:0]            s_bresp,
  output logic                  s_bready,
  output logic                  s_arvalid,
  output logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_rready,
  // status
  output logic                  gnt_busy,
  output logic                  gnt_master
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WA   = 3'd1,
    ST_WD   = 3'd2,
    ST_WB   = 3'd3,
    ST_RA   = 3'd4,
    ST_RR   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_master_q, gnt_master_d;
  logic        gnt_is_wr_q, gnt_is_wr_d;
  logic        gnt_both_q, gnt_both_d;   // granted master offered aw and ar together
  logic        rr_prio_q, rr_prio_d;
  logic [1:0]  wr_first_q, wr_first_d;

  // Granted-master view of the master-side inputs.
  logic                 g_wvalid_s, g_bready_s, g_rready_s;
  logic [ADDR_W-1:0]    g_awaddr_s, g_araddr_s;
  logic [DATA_W-1:0]    g_wdata_s;
  logic [DATA_W/8-1:0]  g_wstrb_s;

  assign g_wvalid_s = gnt_master_q ? m1_wvalid : m0_wvalid;
  assign g_bready_s = gnt_master_q ? m1_bready : m0_bready;
  assign g_rready_s = gnt_master_q ? m1_rready : m0_rready;
  assign g_awaddr_s = gnt_master_q ? m1_awaddr : m0_awaddr;
  assign g_araddr_s = gnt_master_q ? m1_araddr : m0_araddr;
  assign g_wdata_s  = gnt_master_q ? m1_wdata  : m0_wdata;
  assign g_wstrb_s  = gnt_master_q ? m1_wstrb  : m0_wstrb;

  // Arbitration decision evaluated in IDLE.
  logic req0_s, req1_s, sel_s, sel_aw_s, sel_ar_s, sel_both_s, sel_wr_s;

  assign req0_s     = m0_awvalid | m0_arvalid;
  assign req1_s     = m1_awvalid | m1_arvalid;
  assign sel_s      = (req0_s & req1_s) ? rr_prio_q : req1_s;
  assign sel_aw_s   = sel_s ? m1_awvalid : m0_awvalid;
  assign sel_ar_s   = sel_s ? m1_arvalid : m0_arvalid;
  assign sel_both_s = sel_aw_s & sel_ar_s;
  assign sel_wr_s   = sel_both_s ? wr_first_q[sel_s] : sel_aw_s;

  // State and grant registers with synchronous reset.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      state_q      <= ST_IDLE;
      gnt_master_q <= 1'b0;
      gnt_is_wr_q  <= 1'b0;
      gnt_both_q   <= 1'b0;
      rr_prio_q    <= 1'b0;
      wr_first_q   <= 2'b11;
    end else begin
      state_q      <= state_d;
      gnt_master_q <= gnt_master_d;
      gnt_is_wr_q  <= gnt_is_wr_d;
      gnt_both_q   <= gnt_both_d;
      rr_prio_q    <= rr_prio_d;
      wr_first_q   <= wr_first_d;
    end
  end

  // Next-state logic: grant in IDLE, walk the channels, rotate priority on completion.
  logic done_s;
  always_comb begin
    state_d      = state_q;
    gnt_master_d = gnt_master_q;
    gnt_is_wr_d  = gnt_is_wr_q;
    gnt_both_d   = gnt_both_q;
    rr_prio_d    = rr_prio_q;
    wr_first_d   = wr_first_q;
    done_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_s | req1_s) begin
          gnt_master_d = sel_s;
          gnt_is_wr_d  = sel_wr_s;
          gnt_both_d   = sel_both_s;
          state_d      = sel_wr_s ? ST_WA : ST_RA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WA: begin
        if (s_awready) state_d = ST_WD;
        else           state_d = ST_WA;
      end
      ST_WD: begin
        if (g_wvalid_s & s_wready) state_d = ST_WB;
        else                       state_d = ST_WD;
      end
      ST_WB: begin
        if (s_bvalid & g_bready_s) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_RA: begin
        if (s_arready) state_d = ST_RR;
        else           state_d = ST_RA;
      end
      ST_RR: begin
        if (s_rvalid & g_rready_s) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = ST_RR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The write/read preference only flips when the master actually had a choice.
    if (done_s) begin
      rr_prio_d = ~gnt_master_q;
      if (gnt_both_q) begin
        if (gnt_master_q) wr_first_d = {~gnt_is_wr_q, wr_first_q[0]};
        else              wr_first_d = {wr_first_q[1], ~gnt_is_wr_q};
      end else begin
        wr_first_d = wr_first_q;
      end
    end else begin
      rr_prio_d = rr_prio_q;
    end
  end

  // Channel forwarding: drive the slave and route responses to the granted master only.
  logic            g_awready_s, g_wready_s, g_bvalid_s, g_arready_s, g_rvalid_s;
  logic [1:0]      g_bresp_s, g_rresp_s;
  logic [DATA_W-1:0] g_rdata_s;
  always_comb begin
    s_awvalid   = 1'b0;
    s_awaddr    = '0;
    s_wvalid    = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_bready    = 1'b0;
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_rready    = 1'b0;
    g_awready_s = 1'b0;
    g_wready_s  = 1'b0;
    g_bvalid_s  = 1'b0;
    g_bresp_s   = 2'b00;
    g_arready_s = 1'b0;
    g_rvalid_s  = 1'b0;
    g_rdata_s   = '0;
    g_rresp_s   = 2'b00;
    case (state_q)
      ST_WA: begin
        s_awvalid   = 1'b1;
        s_awaddr    = g_awaddr_s;
        g_awready_s = s_awready;
      end
      ST_WD: begin
        s_wvalid   = g_wvalid_s;
        s_wdata    = g_wdata_s;
        s_wstrb    = g_wstrb_s;
        g_wready_s = s_wready;
      end
      ST_WB: begin
        s_bready   = g_bready_s;
        g_bvalid_s = s_bvalid;
        g_bresp_s  = s_bresp;
      end
      ST_RA: begin
        s_arvalid   = 1'b1;
        s_araddr    = g_araddr_s;
        g_arready_s = s_arready;
      end
      ST_RR: begin
        s_rready   = g_rready_s;
        g_rvalid_s = s_rvalid;
        g_rdata_s  = s_rdata;
        g_rresp_s  = s_rresp;
      end
      default: begin
        s_awvalid = 1'b0;
      end
    endcase

    m0_awready = ~gnt_master_q & g_awready_s;
    m0_wready  = ~gnt_master_q & g_wready_s;
    m0_bvalid  = ~gnt_master_q & g_bvalid_s;
    m0_bresp   = gnt_master_q ? 2'b00 : g_bresp_s;
    m0_arready = ~gnt_master_q & g_arready_s;
    m0_rvalid  = ~gnt_master_q & g_rvalid_s;
    m0_rdata   = gnt_master_q ? '0 : g_rdata_s;
    m0_rresp   = gnt_master_q ? 2'b00 : g_rresp_s;
    m1_awready = gnt_master_q & g_awready_s;
    m1_wready  = gnt_master_q & g_wready_s;
    m1_bvalid  = gnt_master_q & g_bvalid_s;
    m1_bresp   = gnt_master_q ? g_bresp_s : 2'b00;
    m1_arready = gnt_master_q & g_arready_s;
    m1_rvalid  = gnt_master_q & g_rvalid_s;
    m1_rdata   = gnt_master_q ? g_rdata_s : '0;
    m1_rresp   = gnt_master_q ? g_rresp_s : 2'b00;
  end

  assign gnt_busy   = (state_q != ST_IDLE);
  assign gnt_master = gnt_master_q;

endmodule

// File: tb/tb_cl_ocl_arb.sv
// Directed bench for cl_ocl_arb: the bench plays both masters and the slave
// and checks hand-computed expectations after each step.
module tb_cl_ocl_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic [1:0]  m0_bresp, m0_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic [1:0]  m1_bresp, m1_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        gnt_busy, gnt_master;

  int n_vec = 0;
  int n_err = 0;

  cl_ocl_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_main_a0(clk), .rst_main_sync(rst),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .gnt_busy(gnt_busy), .gnt_master(gnt_master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_awvalid = 1'b0; m0_awaddr = 32'h0; m0_wvalid = 1'b0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m0_bready = 1'b0; m0_arvalid = 1'b0; m0_araddr = 32'h0; m0_rready = 1'b0;
    m1_awvalid = 1'b0; m1_awaddr = 32'h0; m1_wvalid = 1'b0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    m1_bready = 1'b0; m1_arvalid = 1'b0; m1_araddr = 32'h0; m1_rready = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
  endtask

  initial begin
    logic exp_g;
    logic exp_wr;
    clear_inputs();

    // ---- reset state
    rst = 1'b1;
    step(); step();
    chk("rst_busy", gnt_busy, 1'b0);
    chk("rst_gnt", gnt_master, 1'b0);
    chk("rst_valids", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 5'b0);
    chk("rst_mresp", {m0_bvalid, m0_rvalid, m1_bvalid, m1_rvalid}, 4'b0);
    rst = 1'b0;
    step();

    // ---- single read from m0
    m0_arvalid = 1'b1; m0_araddr = 32'h0;
    #1;
    chk("t1_idle_arvalid", s_arvalid, 1'b0);
    step();
    chk("t1_arvalid", s_arvalid, 1'b1);
    chk("t1_araddr", s_araddr, 32'h0);
    chk("t1_gnt", gnt_master, 1'b0);
    s_arready = 1'b1;
    #1;
    chk("t1_arready", {m0_arready, m1_arready}, 2'b10);
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h6F6C6C65; m0_rready = 1'b1;
    #1;
    chk("t1_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("t1_rdata", m0_rdata, 32'h6F6C6C65);
    chk("t1_m1_rdata", m1_rdata, 32'h0);
    chk("t1_rready", s_rready, 1'b1);
    step();
    s_rvalid = 1'b0; m0_rready = 1'b0;
    #1;
    chk("t1_done", gnt_busy, 1'b0);

    // ---- single write from m1
    m1_awvalid = 1'b1; m1_awaddr = 32'h4; m1_wvalid = 1'b1; m1_wdata = 32'h0000A5A5;
    m1_wstrb = 4'hF; m1_bready = 1'b1;
    #1;
    chk("t2_idle_awvalid", s_awvalid, 1'b0);
    step();
    chk("t2_awvalid", s_awvalid, 1'b1);
    chk("t2_awaddr", s_awaddr, 32'h4);
    chk("t2_no_w_yet", s_wvalid, 1'b0);
    chk("t2_gnt", gnt_master, 1'b1);
    s_awready = 1'b1;
    #1;
    chk("t2_awready", {m0_awready, m1_awready}, 2'b01);
    step();
    m1_awvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b1;
    #1;
    chk("t2_wvalid", {s_awvalid, s_wvalid}, 2'b01);
    chk("t2_wdata", s_wdata, 32'h0000A5A5);
    chk("t2_wstrb", s_wstrb, 4'hF);
    chk("t2_wready", {m0_wready, m1_wready}, 2'b01);
    step();
    m1_wvalid = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b00;
    #1;
    chk("t2_bvalid", {m0_bvalid, m1_bvalid}, 2'b01);
    chk("t2_bresp", m1_bresp, 2'b00);
    chk("t2_bready", s_bready, 1'b1);
    step();
    s_bvalid = 1'b0; m1_bready = 1'b0;
    #1;
    chk("t2_done", {gnt_busy, gnt_master}, 2'b01);

    // ---- both masters reading continuously: m0 first, then alternate
    clear_inputs();
    m0_arvalid = 1'b1; m0_araddr = 32'h10; m0_rready = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h20; m1_rready = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 1);
      s_rdata = 32'hCAFE0000 + i;
      step();
      chk("t3_gnt", gnt_master, exp_g);
      chk("t3_araddr", s_araddr, exp_g ? 32'h20 : 32'h10);
      step();
      chk("t3_rvalid", {m0_rvalid, m1_rvalid}, exp_g ? 2'b01 : 2'b10);
      chk("t3_rdata", exp_g ? m1_rdata : m0_rdata, 32'hCAFE0000 + i);
      step();
      chk("t3_idle", gnt_busy, 1'b0);
    end

    // ---- m0 holding aw and ar: write, read, write, read
    clear_inputs();
    m0_awvalid = 1'b1; m0_awaddr = 32'h30; m0_arvalid = 1'b1; m0_araddr = 32'h34;
    m0_wvalid = 1'b1; m0_wdata = 32'h55; m0_wstrb = 4'hF; m0_bready = 1'b1; m0_rready = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_wr = (i % 2 == 0);
      step();
      chk("t4_op", {s_awvalid, s_arvalid}, exp_wr ? 2'b10 : 2'b01);
      for (int k = 0; k < 8 && gnt_busy; k++) step();
      chk("t4_complete", gnt_busy, 1'b0);
    end

    // ---- slow read on m0 while m1 waits
    clear_inputs();
    m0_arvalid = 1'b1; m0_araddr = 32'h40;
    step();
    chk("t5_gnt0", gnt_master, 1'b0);
    m1_arvalid = 1'b1; m1_araddr = 32'h44; s_arready = 1'b1;
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0; m0_rready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("t5_wait_rr", {gnt_busy, gnt_master, s_rready, s_arvalid, m0_rvalid}, 5'b10100);
      step();
    end
    s_rvalid = 1'b1; s_rdata = 32'h12345678; s_rresp = 2'b10;
    #1;
    chk("t5_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("t5_rresp", m0_rresp, 2'b10);
    step();
    s_rvalid = 1'b0; m0_rready = 1'b0;
    #1;
    chk("t5_idle", gnt_busy, 1'b0);
    step();
    chk("t5_gnt1", gnt_master, 1'b1);
    chk("t5_araddr", s_araddr, 32'h44);
    s_arready = 1'b1;
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; m1_rready = 1'b1;
    step();
    s_rvalid = 1'b0; m1_rready = 1'b0;
    #1;
    chk("t5_done", gnt_busy, 1'b0);

    // ---- reset while in WD, then fresh traffic
    clear_inputs();
    m0_arvalid = 1'b1;
    step();
    s_arready = 1'b1;
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1;
    step();
    s_rvalid = 1'b0; m0_rready = 1'b0;
    m0_awvalid = 1'b1; m0_awaddr = 32'h8; m0_wvalid = 1'b1; m0_wdata = 32'h77; m0_wstrb = 4'hF;
    step();
    s_awready = 1'b1;
    step();
    m0_awvalid = 1'b0; s_awready = 1'b0;
    #1;
    chk("t6_in_wd", s_wvalid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0; m0_wvalid = 1'b0;
    #1;
    chk("t6_rst_valids", {s_awvalid, s_wvalid, s_arvalid, m0_wready, m0_awready}, 5'b0);
    chk("t6_rst_state", {gnt_busy, gnt_master}, 2'b00);
    m0_arvalid = 1'b1; m0_araddr = 32'hC;
    m1_awvalid = 1'b1; m1_awaddr = 32'h4; m1_wvalid = 1'b1; m1_wdata = 32'hBEEF;
    m1_wstrb = 4'h3; m1_bready = 1'b1;
    step();
    chk("t6_prio0", {gnt_master, s_arvalid, s_awvalid}, 3'b010);
    s_arready = 1'b1;
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1;
    step();
    s_rvalid = 1'b0; m0_rready = 1'b0;
    step();
    chk("t6_m1_gnt", {gnt_master, s_awvalid}, 2'b11);
    chk("t6_awaddr", s_awaddr, 32'h4);
    s_awready = 1'b1;
    step();
    m1_awvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b1;
    #1;
    chk("t6_wdata", s_wdata, 32'hBEEF);
    chk("t6_wstrb", s_wstrb, 4'h3);
    step();
    m1_wvalid = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b01;
    #1;
    chk("t6_bvalid", {m0_bvalid, m1_bvalid}, 2'b01);
    chk("t6_bresp", m1_bresp, 2'b01);
    step();
    s_bvalid = 1'b0; m1_bready = 1'b0;
    #1;
    chk("t6_done", gnt_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
